// File: rtl/cluster_pkg.sv
// Constants and cluster word layout shared by the cluster packer and the cluster expander.
package cluster_pkg;

    localparam int MXVPF  = 768;
    localparam int MXADRB = 11;
    localparam int MXCNTB = 3;
    localparam int MXCLST = 8;

    localparam logic [MXADRB-1:0] INVALID_ADR = 11'h7FE;
    localparam logic [MXADRB-1:0] MXVPF_ADR   = MXADRB'(MXVPF);
    localparam logic [3:0]        MXCLST_CNT  = 4'(MXCLST);

    typedef struct packed {
        logic [MXCNTB-1:0] cnt;
        logic [MXADRB-1:0] adr;
    } cluster_word_t;

    function automatic logic adr_valid(input logic [MXADRB-1:0] adr);
        return adr < MXVPF_ADR;
    endfunction

endpackage

// File: rtl/cluster_span_decode.sv
// Combinational {adr,cnt} -> run mask of cnt+1 bits starting at adr, clipped at the top of the map.
module cluster_span_decode
    import cluster_pkg::*;
(
    input  logic [MXADRB-1:0] adr,
    input  logic [MXCNTB-1:0] cnt,
    output logic [MXVPF-1:0]  mask
);

    logic [MXVPF-1:0] onehot;

    always_comb begin
        onehot = '0;
        if (adr_valid(adr)) onehot = MXVPF'(1) << adr;
        mask = onehot;
        // Left shifts drop bits past MXVPF-1, which gives the clipping for free.
        for (int k = 1; k < (1 << MXCNTB); k++) begin
            if (32'(cnt) >= k) mask = mask | (onehot << k);
        end
    end

endmodule

// File: rtl/cluster_expander.sv
// Rebuilds the per-BX VPF bitmap from the serial {adr,cnt} cluster stream, closing a frame on latch_pulse.
module cluster_expander
    import cluster_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              latch_pulse,
    input  logic              cluster_vld,
    input  logic [MXADRB-1:0] cluster_adr,
    input  logic [MXCNTB-1:0] cluster_cnt,
    output logic [MXVPF-1:0]  vpfs_out,
    output logic              vpfs_valid,
    output logic [3:0]        n_clusters,
    output logic              overflow,
    output logic              invalid_seen
);

    logic [MXVPF-1:0] span_mask;

    cluster_span_decode u_span (
        .adr  (cluster_adr),
        .cnt  (cluster_cnt),
        .mask (span_mask)
    );

    logic [MXVPF-1:0] acc_q, acc_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             inv_q, inv_d;

    logic [MXVPF-1:0] vpfs_q, vpfs_d;
    logic             strobe_q, strobe_d;
    logic [3:0]       ncl_q, ncl_d;
    logic             fovf_q, fovf_d;
    logic             finv_q, finv_d;

    logic [MXVPF-1:0] base_acc;
    logic [3:0]       base_cnt;
    logic             base_ovf, base_inv;
    logic             word_ok, word_bad, room, accept;

    always_comb begin
        // A word on the latch clock starts the new frame, so it sees cleared frame state.
        base_acc = latch_pulse ? '0   : acc_q;
        base_cnt = latch_pulse ? 4'd0 : cnt_q;
        base_ovf = latch_pulse ? 1'b0 : ovf_q;
        base_inv = latch_pulse ? 1'b0 : inv_q;

        word_ok  = cluster_vld &&  adr_valid(cluster_adr);
        word_bad = cluster_vld && !adr_valid(cluster_adr);
        room     = base_cnt < MXCLST_CNT;
        accept   = word_ok && room;

        acc_d = base_acc | (accept ? span_mask : '0);
        cnt_d = base_cnt + {3'd0, accept};
        ovf_d = base_ovf | (word_ok && !room);
        inv_d = base_inv | word_bad;

        strobe_d = latch_pulse;
        vpfs_d   = latch_pulse ? acc_q : vpfs_q;
        ncl_d    = latch_pulse ? cnt_q : ncl_q;
        fovf_d   = latch_pulse ? ovf_q : fovf_q;
        finv_d   = latch_pulse ? inv_q : finv_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            inv_q    <= 1'b0;
            vpfs_q   <= '0;
            strobe_q <= 1'b0;
            ncl_q    <= '0;
            fovf_q   <= 1'b0;
            finv_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            inv_q    <= inv_d;
            vpfs_q   <= vpfs_d;
            strobe_q <= strobe_d;
            ncl_q    <= ncl_d;
            fovf_q   <= fovf_d;
            finv_q   <= finv_d;
        end
    end

    assign vpfs_out     = vpfs_q;
    assign vpfs_valid   = strobe_q;
    assign n_clusters   = ncl_q;
    assign overflow     = fovf_q;
    assign invalid_seen = finv_q;

endmodule

// File: tb/tb_cluster_expander.sv
// Bench for cluster_expander: constant vector table, hand sequences, random stream and loopback vs a bit-array model.
module tb_cluster_expander;
    import cluster_pkg::*;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              latch_pulse;
    logic              cluster_vld;
    logic [MXADRB-1:0] cluster_adr;
    logic [MXCNTB-1:0] cluster_cnt;
    logic [MXVPF-1:0]  vpfs_out;
    logic              vpfs_valid;
    logic [3:0]        n_clusters;
    logic              overflow;
    logic              invalid_seen;

    always #5 clock = ~clock;

    cluster_expander dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .latch_pulse  (latch_pulse),
        .cluster_vld  (cluster_vld),
        .cluster_adr  (cluster_adr),
        .cluster_cnt  (cluster_cnt),
        .vpfs_out     (vpfs_out),
        .vpfs_valid   (vpfs_valid),
        .n_clusters   (n_clusters),
        .overflow     (overflow),
        .invalid_seen (invalid_seen)
    );

    int errors = 0;
    int checks = 0;

    // Model: frame in progress and the last closed frame.
    logic [MXVPF-1:0] m_acc, e_map;
    int m_n, e_n;
    int m_ovf, m_inv, e_ovf, e_inv;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [MXVPF-1:0] got, input logic [MXVPF-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic m_clear();
        m_acc = '0; m_n = 0; m_ovf = 0; m_inv = 0;
    endtask

    task automatic m_word(input int adr, input int cnt);
        if (adr < MXVPF) begin
            if (m_n < MXCLST) begin
                for (int j = 0; j <= cnt; j++) if (adr + j < MXVPF) m_acc[adr + j] = 1'b1;
                m_n++;
            end else m_ovf = 1;
        end else m_inv = 1;
    endtask

    task automatic m_latch();
        e_map = m_acc; e_n = m_n; e_ovf = m_ovf; e_inv = m_inv;
        m_clear();
    endtask

    // One clock of stimulus, mirrored into the model, with outputs checked #1 after the edge.
    task automatic cyc(input int vld, input int adr, input int cnt, input int lp, input string tag);
        if (lp != 0) m_latch();
        if (vld != 0) m_word(adr, cnt);
        cluster_vld = (vld != 0);
        cluster_adr = MXADRB'(adr);
        cluster_cnt = MXCNTB'(cnt);
        latch_pulse = (lp != 0);
        @(posedge clock); #1;
        if (lp != 0) begin
            chk({tag, ".valid"}, int'(vpfs_valid), 1);
            chkv({tag, ".map"}, vpfs_out, e_map);
            chk({tag, ".n"}, int'(n_clusters), e_n);
            chk({tag, ".ovf"}, int'(overflow), e_ovf);
            chk({tag, ".inv"}, int'(invalid_seen), e_inv);
        end else begin
            chk({tag, ".nostrobe"}, int'(vpfs_valid), 0);
            chkv({tag, ".hold"}, vpfs_out, e_map);
        end
    endtask

    function automatic logic [MXVPF-1:0] range_map(input int lo, input int hi);
        logic [MXVPF-1:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    typedef struct {
        int adr; int cnt; int lo; int hi; int n; int inv;
    } vec_t;
    vec_t tbl[8];

    logic [MXVPF-1:0] exp_map, src;
    int q_adr[$];
    int q_cnt[$];

    initial begin
        tbl[0] = '{adr: 100, cnt: 2, lo: 100, hi: 102, n: 1, inv: 0};
        tbl[1] = '{adr: 766, cnt: 4, lo: 766, hi: 767, n: 1, inv: 0};
        tbl[2] = '{adr: 0,   cnt: 7, lo: 0,   hi: 7,   n: 1, inv: 0};
        tbl[3] = '{adr: 767, cnt: 0, lo: 767, hi: 767, n: 1, inv: 0};
        tbl[4] = '{adr: 760, cnt: 7, lo: 760, hi: 767, n: 1, inv: 0};
        tbl[5] = '{adr: 768, cnt: 0, lo: 1,   hi: 0,   n: 0, inv: 1};
        tbl[6] = '{adr: 'h7FE, cnt: 3, lo: 1, hi: 0,   n: 0, inv: 1};
        tbl[7] = '{adr: 'h7FF, cnt: 7, lo: 1, hi: 0,   n: 0, inv: 1};

        reset_n = 1'b0; latch_pulse = 1'b0; cluster_vld = 1'b0;
        cluster_adr = '0; cluster_cnt = '0;
        m_clear(); m_latch();

        // Reset, with a latch_pulse held during reset to show reset wins.
        for (int i = 0; i < 3; i++) begin
            latch_pulse = (i == 1);
            cluster_vld = 1'b1; cluster_adr = 11'd9;
            @(posedge clock); #1;
            chk("rst.valid", int'(vpfs_valid), 0);
            chkv("rst.map", vpfs_out, '0);
            chk("rst.n", int'(n_clusters), 0);
            chk("rst.flags", int'({overflow, invalid_seen}), 0);
        end
        reset_n = 1'b1;
        cyc(0, 0, 0, 0, "post_rst");
        cyc(0, 0, 0, 0, "post_rst");
        cyc(0, 0, 0, 1, "first_latch");
        chkv("first_latch.zero", vpfs_out, '0);
        cyc(0, 0, 0, 0, "strobe_once");

        // Single-cluster frames from the constant table.
        for (int t = 0; t < 8; t++) begin
            cyc(1, tbl[t].adr, tbl[t].cnt, 0, "tbl.word");
            cyc(0, 0, 0, 1, "tbl.latch");
            exp_map = (tbl[t].lo <= tbl[t].hi) ? range_map(tbl[t].lo, tbl[t].hi) : '0;
            chkv($sformatf("tbl%0d.map", t), vpfs_out, exp_map);
            chk($sformatf("tbl%0d.n", t), int'(n_clusters), tbl[t].n);
            chk($sformatf("tbl%0d.inv", t), int'(invalid_seen), tbl[t].inv);
        end

        // Edge clip plus an invalid word in the same frame.
        cyc(1, 766, 4, 0, "clip");
        cyc(1, 'h7FF, 0, 0, "clip");
        cyc(0, 0, 0, 1, "clip.latch");
        chkv("clip.map", vpfs_out, range_map(766, 767));
        chk("clip.bit0", int'(vpfs_out[0]), 0);
        chk("clip.n", int'(n_clusters), 1);
        chk("clip.inv", int'(invalid_seen), 1);

        // Ten clusters into an eight-deep frame.
        for (int k = 0; k < 10; k++) cyc(1, 10 * k, 0, 0, "ovf");
        cyc(0, 0, 0, 1, "ovf.latch");
        exp_map = '0;
        for (int k = 0; k < 8; k++) exp_map[10 * k] = 1'b1;
        chkv("ovf.map", vpfs_out, exp_map);
        chk("ovf.n", int'(n_clusters), 8);
        chk("ovf.flag", int'(overflow), 1);
        chk("ovf.bit80", int'(vpfs_out[80]), 0);

        // Duplicate clusters are OR'ed but both count.
        cyc(1, 300, 1, 0, "dup");
        cyc(1, 300, 1, 0, "dup");
        cyc(0, 0, 0, 1, "dup.latch");
        chkv("dup.map", vpfs_out, range_map(300, 301));
        chk("dup.n", int'(n_clusters), 2);

        // Word on the latch clock belongs to the next frame.
        cyc(1, 200, 0, 0, "bnd");
        cyc(1, 5, 0, 1, "bnd.latch1");
        chkv("bnd.cur", vpfs_out, range_map(200, 200));
        chk("bnd.cur_n", int'(n_clusters), 1);
        cyc(0, 0, 0, 1, "bnd.latch2");
        chkv("bnd.next", vpfs_out, range_map(5, 5));
        chk("bnd.next_n", int'(n_clusters), 1);

        // Back-to-back latch pulses give empty frames, each strobed.
        cyc(0, 0, 0, 1, "empty");
        chkv("empty.map", vpfs_out, '0);
        cyc(0, 0, 0, 1, "empty2");

        // Reset mid-frame discards the partial frame.
        cyc(1, 50, 1, 0, "midrst");
        reset_n = 1'b0; cluster_vld = 1'b0;
        @(posedge clock); #1;
        chk("midrst.valid", int'(vpfs_valid), 0);
        chkv("midrst.map", vpfs_out, '0);
        reset_n = 1'b1;
        m_clear(); m_latch();
        cyc(0, 0, 0, 1, "midrst.latch");
        chk("midrst.n", int'(n_clusters), 0);

        // Random stream against the model.
        for (int f = 0; f < 1500; f++) begin
            int nw;
            nw = $urandom_range(0, 11);
            for (int w = 0; w <= nw; w++) begin
                int r, adr;
                r = $urandom % 16;
                adr = (r == 0) ? 'h7FE : (r == 1) ? 'h7FF :
                      (r == 2) ? $urandom_range(760, 767) : $urandom_range(0, MXVPF - 1);
                cyc(($urandom % 4) != 0, adr, $urandom % 8, w == nw, "rnd");
            end
        end

        // Loopback: sparse random map -> run encoder -> expander.
        cyc(0, 0, 0, 1, "lb.flush");
        for (int f = 0; f < 1000; f++) begin
            int i;
            src = '0;
            for (int b = 0; b < MXVPF; b++) if ($urandom % 128 == 0) src[b] = 1'b1;
            if (f % 3 == 0) src[MXVPF-1] = 1'b1;
            q_adr.delete(); q_cnt.delete();
            i = 0;
            while (i < MXVPF) begin
                if (src[i]) begin
                    int len;
                    len = 0;
                    while (i + len < MXVPF && src[i + len] && len < 8) len++;
                    q_adr.push_back(i); q_cnt.push_back(len - 1);
                    i += len;
                end else i++;
            end
            for (int c = 0; c < q_adr.size() && c < MXCLST; c++) cyc(1, q_adr[c], q_cnt[c], 0, "lb");
            cyc(0, 0, 0, 1, "lb.latch");
            if (q_adr.size() <= MXCLST) chkv("lb.equal", vpfs_out, src);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
